// File: rtl/jcpu_pkg.sv
// jcpu_pkg: shared constants for the 8-bit CPU control path.
//   - opcode encodings (IR[7:4]), ALU function codes, flag bit indices
//   - phase constants for the four-phase step timing
//   - ctrl_t bundle of raw (ungated) datapath control signals
//   - dec2: 2-bit register select to one-hot R0..R3
package jcpu_pkg;

    // Opcodes, IR[7:4]. Any opcode with bit 3 set is an ALU instruction.
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_DATA  = 4'b0010;
    localparam logic [3:0] OP_JMPR  = 4'b0011;
    localparam logic [3:0] OP_JMP   = 4'b0100;
    localparam logic [3:0] OP_JMPIF = 4'b0101;
    localparam logic [3:0] OP_CLF   = 4'b0110;
    localparam logic [3:0] OP_IO    = 4'b0111;
    localparam int unsigned OP_ALU_BIT = 3;

    // ALU function codes, IR[6:4] of an ALU instruction.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHR = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // Flag bit indices within {C, A, E, Z}.
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_A = 2;
    localparam int unsigned FLAG_E = 1;
    localparam int unsigned FLAG_Z = 0;

    // Phase within a step: set strobes fire in PH_SET, PH_LAST is idle.
    localparam logic [1:0] PH_SET  = 2'd1;
    localparam logic [1:0] PH_LAST = 2'd3;

    typedef struct packed {
        logic [3:0] en_r;
        logic [3:0] set_r;
        logic       en_ram;
        logic       set_ram;
        logic       set_mar;
        logic       en_iar;
        logic       set_iar;
        logic       en_acc;
        logic       set_acc;
        logic       set_tmp;
        logic       set_ir;
        logic       set_flags;
        logic       bus1;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic [3:0] dec2(input logic [1:0] sel);
        dec2 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/jstep_seq.sv
// jstep_seq: four-phase step timing plus one-hot six-step ring.
//   clk, reset : system clock, synchronous active-high reset
//   step       : one-hot current step, bit 0 = step 1
//   phase      : quarter within the step, 0..3
//   en_win     : high in phases 0..2 (enable-class outputs valid)
//   set_win    : high in phase 1 only (set-class strobe window)
module jstep_seq
    import jcpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] step,
    output logic [1:0] phase,
    output logic       en_win,
    output logic       set_win
);

    logic [1:0] phase_q, phase_d;
    logic [5:0] step_q, step_d;

    always_comb begin
        phase_d = phase_q + 2'd1;
        step_d  = step_q;
        // Rotate the ring on the last phase; step 6 wraps back to step 1.
        if (phase_q == PH_LAST) begin
            step_d = {step_q[4:0], step_q[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 2'd0;
            step_q  <= 6'b000001;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    assign step    = step_q;
    assign phase   = phase_q;
    assign en_win  = (phase_q != PH_LAST);
    assign set_win = (phase_q == PH_SET);

endmodule

// File: rtl/jcontrol.sv
// jcontrol: control unit of the 8-bit CPU.
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : shared bus, loaded into the internal IR on set_ir
//   flags        : latched {C, A, E, Z}, used by JMPIF in step 6
//   step, phase  : one-hot step (bit 0 = step 1) and phase 0..3
//   en_*, bus1   : bus source enables, valid in phases 0..2
//   set_*        : register set strobes, phase 1 only
//   alu_op       : ALU function, ADD except in ALU step 5
// Decode is combinational from the step ring and IR, then gated by the
// phase windows and by reset so every control is low while reset is high.
module jcontrol
    import jcpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus,
    input  logic [3:0] flags,
    output logic [5:0] step,
    output logic [1:0] phase,
    output logic [3:0] en_r,
    output logic [3:0] set_r,
    output logic       en_ram,
    output logic       set_ram,
    output logic       set_mar,
    output logic       en_iar,
    output logic       set_iar,
    output logic       en_acc,
    output logic       set_acc,
    output logic       set_tmp,
    output logic       set_ir,
    output logic       set_flags,
    output logic       bus1,
    output logic [2:0] alu_op
);

    logic       en_win;
    logic       set_win;
    logic       en_gate;
    logic       set_gate;
    logic [7:0] ir_q, ir_d;
    logic [3:0] opcode;
    logic [1:0] ra;
    logic [1:0] rb;
    ctrl_t      raw;

    jstep_seq u_step (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .phase   (phase),
        .en_win  (en_win),
        .set_win (set_win)
    );

    assign opcode = ir_q[7:4];
    assign ra     = ir_q[3:2];
    assign rb     = ir_q[1:0];

    always_comb begin
        raw = '0;
        unique case (1'b1)
            step[0]: begin
                raw.bus1    = 1'b1;
                raw.en_iar  = 1'b1;
                raw.set_mar = 1'b1;
                raw.set_acc = 1'b1;
            end
            step[1]: begin
                raw.en_ram = 1'b1;
                raw.set_ir = 1'b1;
            end
            step[2]: begin
                raw.en_acc  = 1'b1;
                raw.set_iar = 1'b1;
            end
            step[3]: begin
                if (opcode[OP_ALU_BIT]) begin
                    raw.en_r    = dec2(rb);
                    raw.set_tmp = 1'b1;
                end else begin
                    unique case (opcode)
                        OP_LOAD, OP_STORE: begin
                            raw.en_r    = dec2(ra);
                            raw.set_mar = 1'b1;
                        end
                        OP_DATA, OP_JMPIF: begin
                            raw.bus1    = 1'b1;
                            raw.en_iar  = 1'b1;
                            raw.set_mar = 1'b1;
                            raw.set_acc = 1'b1;
                        end
                        OP_JMPR: begin
                            raw.en_r    = dec2(rb);
                            raw.set_iar = 1'b1;
                        end
                        OP_JMP: begin
                            raw.en_iar  = 1'b1;
                            raw.set_mar = 1'b1;
                        end
                        OP_CLF: begin
                            raw.bus1      = 1'b1;
                            raw.set_flags = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            step[4]: begin
                if (opcode[OP_ALU_BIT]) begin
                    raw.en_r      = dec2(ra);
                    raw.alu_op    = opcode[2:0];
                    raw.set_acc   = 1'b1;
                    raw.set_flags = 1'b1;
                end else begin
                    unique case (opcode)
                        OP_LOAD, OP_DATA: begin
                            raw.en_ram = 1'b1;
                            raw.set_r  = dec2(rb);
                        end
                        OP_STORE: begin
                            raw.en_r    = dec2(rb);
                            raw.set_ram = 1'b1;
                        end
                        OP_JMP: begin
                            raw.en_ram  = 1'b1;
                            raw.set_iar = 1'b1;
                        end
                        OP_JMPIF: begin
                            raw.en_acc  = 1'b1;
                            raw.set_iar = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            step[5]: begin
                if (opcode[OP_ALU_BIT]) begin
                    // CMP only updates flags; the result is not written back.
                    if (opcode[2:0] != ALU_CMP) begin
                        raw.en_acc = 1'b1;
                        raw.set_r  = dec2(rb);
                    end
                end else begin
                    unique case (opcode)
                        OP_DATA: begin
                            raw.en_acc  = 1'b1;
                            raw.set_iar = 1'b1;
                        end
                        OP_JMPIF: begin
                            // Taken: load the target byte fetched in step 4.
                            if ((ir_q[3:0] & flags) != 4'b0000) begin
                                raw.en_ram  = 1'b1;
                                raw.set_iar = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign en_gate  = en_win & ~reset;
    assign set_gate = set_win & ~reset;

    assign en_r      = raw.en_r & {4{en_gate}};
    assign en_ram    = raw.en_ram & en_gate;
    assign en_iar    = raw.en_iar & en_gate;
    assign en_acc    = raw.en_acc & en_gate;
    assign bus1      = raw.bus1 & en_gate;
    assign alu_op    = raw.alu_op & {3{en_gate}};
    assign set_r     = raw.set_r & {4{set_gate}};
    assign set_ram   = raw.set_ram & set_gate;
    assign set_mar   = raw.set_mar & set_gate;
    assign set_iar   = raw.set_iar & set_gate;
    assign set_acc   = raw.set_acc & set_gate;
    assign set_tmp   = raw.set_tmp & set_gate;
    assign set_ir    = raw.set_ir & set_gate;
    assign set_flags = raw.set_flags & set_gate;

    always_comb begin
        ir_d = ir_q;
        if (set_ir) begin
            ir_d = bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= 8'h00;
        end else begin
            ir_q <= ir_d;
        end
    end

endmodule

// File: tb/tb_jcontrol.sv
// Directed bench for jcontrol: the control outputs are packed into one word and
// compared against hand-built expected words at chosen (step, phase) points.
// The bench tracks position within the 24-cycle instruction itself (cyc).
module tb_jcontrol;
    import jcpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus;
    logic [3:0] flags;
    logic [5:0] step;
    logic [1:0] phase;
    logic [3:0] en_r, set_r;
    logic       en_ram, set_ram, set_mar, en_iar, set_iar, en_acc, set_acc;
    logic       set_tmp, set_ir, set_flags, bus1;
    logic [2:0] alu_op;
    logic [21:0] ctrl;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bit positions inside ctrl.
    localparam logic [21:0] BUS1   = 22'h1 << 3;
    localparam logic [21:0] SFLAGS = 22'h1 << 4;
    localparam logic [21:0] SIR    = 22'h1 << 5;
    localparam logic [21:0] STMP   = 22'h1 << 6;
    localparam logic [21:0] SACC   = 22'h1 << 7;
    localparam logic [21:0] EACC   = 22'h1 << 8;
    localparam logic [21:0] SIAR   = 22'h1 << 9;
    localparam logic [21:0] EIAR   = 22'h1 << 10;
    localparam logic [21:0] SMAR   = 22'h1 << 11;
    localparam logic [21:0] SRAM   = 22'h1 << 12;
    localparam logic [21:0] ERAM   = 22'h1 << 13;

    function automatic logic [21:0] setr(input logic [3:0] v);
        setr = {4'b0000, v, 14'h0};
    endfunction
    function automatic logic [21:0] enr(input logic [3:0] v);
        enr = {v, 18'h0};
    endfunction
    function automatic logic [21:0] alu(input logic [2:0] v);
        alu = {19'h0, v};
    endfunction

    jcontrol dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .flags     (flags),
        .step      (step),
        .phase     (phase),
        .en_r      (en_r),
        .set_r     (set_r),
        .en_ram    (en_ram),
        .set_ram   (set_ram),
        .set_mar   (set_mar),
        .en_iar    (en_iar),
        .set_iar   (set_iar),
        .en_acc    (en_acc),
        .set_acc   (set_acc),
        .set_tmp   (set_tmp),
        .set_ir    (set_ir),
        .set_flags (set_flags),
        .bus1      (bus1),
        .alu_op    (alu_op)
    );

    assign ctrl = {en_r, set_r, en_ram, set_ram, set_mar, en_iar, set_iar, en_acc,
                   set_acc, set_tmp, set_ir, set_flags, bus1, alu_op};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        cyc = (cyc + 1) % 24;
    endtask

    // Advance to position tgt (0..23) of the current or next instruction.
    task automatic go(input int tgt);
        nxt();
        while (cyc != tgt) nxt();
    endtask

    initial begin
        reset = 1'b1;
        bus   = 8'hAE;  // ALU SHL, RA=3, RB=2
        flags = 4'b0000;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_ctrl", 32'(ctrl), 32'h0);
            chk("rst_step", 32'(step), 32'h01);
            chk("rst_phase", 32'(phase), 32'h0);
        end

        reset = 1'b0;
        cyc   = 0;
        #1;
        chk("n_ctrl", 32'(ctrl), 32'(BUS1 | EIAR));
        go(1);
        chk("n1_ctrl", 32'(ctrl), 32'(BUS1 | EIAR | SMAR | SACC));
        go(3);
        chk("s1p3_idle", 32'(ctrl), 32'h0);
        go(4);
        chk("n4_ctrl", 32'(ctrl), 32'(ERAM));
        go(5);
        chk("n5_setir", 32'(ctrl), 32'(ERAM | SIR));
        go(6);
        chk("n6_ctrl", 32'(ctrl), 32'(ERAM));
        go(13);
        chk("shl_s4", 32'(ctrl), 32'(enr(4'b0100) | STMP));
        chk("shl_step4", 32'(step), 32'h08);
        go(16);
        chk("shl_s5p0", 32'(ctrl), 32'(enr(4'b1000) | alu(ALU_SHL)));
        go(17);
        chk("shl_s5p1", 32'(ctrl), 32'(enr(4'b1000) | alu(ALU_SHL) | SACC | SFLAGS));
        go(19);
        chk("shl_s5p3", 32'(ctrl), 32'h0);
        go(21);
        chk("shl_s6", 32'(ctrl), 32'(EACC | setr(4'b0100)));

        // CMP R0,R1
        go(0);
        chk("wrap_step", 32'(step), 32'h01);
        chk("wrap_phase", 32'(phase), 32'h0);
        bus = 8'hF1;
        go(17);
        chk("cmp_s5", 32'(ctrl), 32'(enr(4'b0001) | alu(ALU_CMP) | SACC | SFLAGS));
        go(21);
        chk("cmp_s6", 32'(ctrl), 32'h0);

        // JMPIF C, carry set
        go(0);
        bus   = 8'h58;
        flags = 4'b1000;
        go(13);
        chk("jif_s4", 32'(ctrl), 32'(BUS1 | EIAR | SMAR | SACC));
        go(17);
        chk("jif_s5", 32'(ctrl), 32'(EACC | SIAR));
        go(21);
        chk("jif_taken", 32'(ctrl), 32'(ERAM | SIAR));
        flags = 4'b0111;
        #1;
        chk("jif_comb", 32'(ctrl), 32'h0);

        // JMPIF C, carry clear
        go(0);
        go(20);
        chk("jif_nt_p0", 32'(ctrl), 32'h0);
        go(21);
        chk("jif_nt_p1", 32'(ctrl), 32'h0);

        // DATA R3
        go(0);
        bus = 8'h2B;
        go(13);
        chk("data_s4", 32'(ctrl), 32'(BUS1 | EIAR | SMAR | SACC));
        go(17);
        chk("data_s5", 32'(ctrl), 32'(ERAM | setr(4'b1000)));
        go(21);
        chk("data_s6", 32'(ctrl), 32'(EACC | SIAR));

        // IO: unimplemented, execute idle
        go(0);
        bus = 8'h70;
        go(13);
        chk("io_s4", 32'(ctrl), 32'h0);
        go(17);
        chk("io_s5", 32'(ctrl), 32'h0);
        go(21);
        chk("io_s6", 32'(ctrl), 32'h0);

        // STORE RA=2, RB=1
        go(0);
        bus = 8'h19;
        go(13);
        chk("st_s4", 32'(ctrl), 32'(enr(4'b0100) | SMAR));
        go(17);
        chk("st_s5", 32'(ctrl), 32'(enr(4'b0010) | SRAM));

        // LOAD RA=1, RB=2, then reset at S5/P1
        go(0);
        bus = 8'h06;
        go(13);
        chk("ld_s4", 32'(ctrl), 32'(enr(4'b0010) | SMAR));
        go(17);
        chk("ld_s5", 32'(ctrl), 32'(ERAM | setr(4'b0100)));
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'(ctrl), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_ctrl2", 32'(ctrl), 32'h0);
        chk("rst_mid_ir", 32'(dut.ir_q), 32'h0);
        chk("rst_mid_step", 32'(step), 32'h01);
        chk("rst_mid_phase", 32'(phase), 32'h0);
        reset = 1'b0;
        cyc   = 0;
        #1;
        chk("restart", 32'(ctrl), 32'(BUS1 | EIAR));

        // Random run: at most one bus source enable per cycle.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus   = 8'($urandom);
            flags = 4'($urandom);
            reset = ($urandom_range(0, 60) == 0);
            #1;
            chk("one_enable",
                32'(($countones(en_r) + 32'(en_ram) + 32'(en_iar) + 32'(en_acc)) <= 1),
                32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
